// File: rtl/bjp_resolve_tracker.sv
// rtl/bjp_resolve_tracker.sv - in-order branch dispatch/resolve tracker emitting classified events
// Optional saturating event counters are built only when BJP_TRK_STAT_EN is defined.
module bjp_resolve_tracker #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_vld,
    input  logic [3:0]       dec_type,
    input  logic [4:0]       dec_rs1_idx,
    input  logic             dec_prdt_taken,
    output logic             dec_rdy,
    input  logic             rsv_vld,
    input  logic             rsv_taken,
    output logic             rsv_rdy,
    input  logic             flush,
    output logic             evt_vld,
    output logic [3:0]       evt_type,
    output logic             evt_miss,
    output logic [PTR_W:0]   occ,
    output logic             err_ovf,
    output logic             err_udf,
    output logic [31:0]      stat_total,
    output logic [31:0]      stat_miss
);

    localparam logic [3:0]     TYPE_JALR = 4'd9;
    localparam logic [3:0]     TYPE_RET  = 4'd10;
    localparam logic [4:0]     RA_IDX    = 5'd1;
    localparam logic [PTR_W:0] OCC_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] OCC_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Each entry packs {type[3:0], predicted_taken}.
    logic [4:0]       ent_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   occ_q;
    logic [PTR_W:0]   occ_d;

    logic             evt_vld_q;
    logic [3:0]       evt_type_q;
    logic             evt_miss_q;
    logic             err_ovf_q;
    logic             err_udf_q;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [3:0]       push_type;
    logic [4:0]       head;
    logic             head_miss;

    assign full    = (occ_q == OCC_FULL);
    assign empty   = (occ_q == '0);
    assign dec_rdy = ~full;
    assign rsv_rdy = ~empty;

    // A push that coincides with a flush would be discarded anyway, so it never enters the FIFO.
    assign push = dec_vld & ~full & ~flush;
    assign pop  = rsv_vld & ~empty;

    // jalr through ra is a function return; classify it once here so the consumer need not.
    always_comb begin
        push_type = dec_type;
        if (dec_type == TYPE_JALR && dec_rs1_idx == RA_IDX) begin
            push_type = TYPE_RET;
        end
    end

    assign head      = ent_mem[rd_ptr_q];
    assign head_miss = head[0] ^ rsv_taken;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_mem[wr_ptr_q] <= {push_type, dec_prdt_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            occ_q <= occ_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
            end
        end
    end

    // The resolving pop still reports its event even when a flush lands in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_vld_q  <= 1'b0;
            evt_type_q <= '0;
            evt_miss_q <= 1'b0;
        end else begin
            evt_vld_q <= pop;
            if (pop) begin
                evt_type_q <= head[4:1];
                evt_miss_q <= head_miss;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (dec_vld && full) begin
                err_ovf_q <= 1'b1;
            end
            if (rsv_vld && empty) begin
                err_udf_q <= 1'b1;
            end
        end
    end

    assign evt_vld  = evt_vld_q;
    assign evt_type = evt_type_q;
    assign evt_miss = evt_miss_q;
    assign occ      = occ_q;
    assign err_ovf  = err_ovf_q;
    assign err_udf  = err_udf_q;

`ifdef BJP_TRK_STAT_EN
    logic [31:0] stat_total_q;
    logic [31:0] stat_miss_q;

    // Counters advance on the same edge that raises evt_vld, so they agree with the event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_total_q <= '0;
            stat_miss_q  <= '0;
        end else if (pop) begin
            if (stat_total_q != 32'hFFFF_FFFF) begin
                stat_total_q <= stat_total_q + 32'd1;
            end
            if (head_miss && stat_miss_q != 32'hFFFF_FFFF) begin
                stat_miss_q <= stat_miss_q + 32'd1;
            end
        end
    end

    assign stat_total = stat_total_q;
    assign stat_miss  = stat_miss_q;
`else
    assign stat_total = '0;
    assign stat_miss  = '0;
`endif

endmodule

// File: doc/bjp_resolve_tracker.md
Name: bjp_resolve_tracker

Overview:
- Sits between the IFU/decode branch dispatch point and the branch-statistics debug counter block.
- Captures each dispatched branch/jump with its type and predicted direction in an in-order FIFO.
- Matches each entry against the execute-stage resolution in order.
- Emits one registered, classified event per resolved branch: type code plus mispredict flag. The statistics block consumes these events instead of raw decode strobes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- dec_vld  in  1  branch accepted at dispatch this cycle
- dec_type  in  4  0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu, 6 beqz, 7 bnez, 8 jal, 9 jalr; 10-15 reserved
- dec_rs1_idx  in  5  rs1 index of the dispatched instruction
- dec_prdt_taken  in  1  predicted taken
- dec_rdy  out  1  FIFO not full
- rsv_vld  in  1  execute resolves the oldest outstanding branch
- rsv_taken  in  1  actual direction
- rsv_rdy  out  1  FIFO not empty
- flush  in  1  pipeline flush (mispredict / trap)
- evt_vld  out  1  one-cycle event strobe
- evt_type  out  4  classified type; 10 = ret
- evt_miss  out  1  prediction mismatched
- occ  out  PTR_W+1  current occupancy
- err_ovf  out  1  sticky: push attempted while full
- err_udf  out  1  sticky: resolve attempted while empty
- stat_total  out  32  see optional feature
- stat_miss  out  32  see optional feature

Behaviour:
- Reset values: all outputs 0, except dec_rdy = 1. Pointers and occupancy are 0; FIFO contents are don't-care.
- Push (dec_vld & dec_rdy): store {type, prdt_taken}.
  - Reclassify at push: type 9 with dec_rs1_idx == 1 is stored as 10 (ret).
  - Type ≥ 10 at input is stored unchanged and flagged nowhere.
- Pop (rsv_vld & rsv_rdy): read head; register evt_vld = 1, evt_type = head type, evt_miss = head prdt_taken XOR rsv_taken.
  - Jal (8) is always predicted taken, so its miss is possible only if the input says so; no special case.
- Latency: event appears the cycle after the resolve handshake. evt_vld is high for exactly one cycle per pop. evt_type and evt_miss hold their last value while evt_vld = 0.
- Push and pop in the same cycle: both occur; occupancy unchanged.
- Full: a simultaneous pop does not re-enable push that cycle (dec_rdy is purely occupancy-based).
- Empty: no bypass. rsv_vld while empty is dropped, err_udf is set, and no event is produced.
- dec_vld while full: dropped, err_ovf set.
- Pointers wrap modulo DEPTH. occ ranges 0..DEPTH.
- Flush:
  - Any pop in the flush cycle completes and its event is emitted.
  - Then all entries are discarded: pointers and occ are 0 the next cycle.
  - A push in the flush cycle is discarded.
  - The err flags are unaffected by flush.
- Error flags clear only on rst.
- Reset mid-operation: asynchronous clear of everything regardless of an in-flight event.

Optional Feature:
- Macro: BJP_TRK_STAT_EN.
- When defined:
  - stat_total increments on every emitted event.
  - stat_miss increments on every emitted event with evt_miss = 1.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF, and are updated in the same cycle as evt_vld rises.
  - Both reset to 0.
- When undefined: the ports remain and are tied to 0; no counter flops.

Test Plan:
- Reset, idle 5 cycles -> dec_rdy = 1, rsv_rdy = 0, occ = 0, evt_vld = 0, errors = 0.
- Push beq pred 1, then resolve taken = 0 -> one cycle later evt_vld = 1, evt_type = 0, evt_miss = 1; occ back to 0.
- Push jalr with rs1 = 1, then jalr with rs1 = 5 (pred 1); resolve both taken -> events type 10 then 9, both miss = 0, in order.
- Push 4 entries (DEPTH = 4) -> dec_rdy = 0, occ = 4. Push a 5th -> err_ovf = 1, occ stays 4. Same-cycle push+pop at occ = 2 -> occ stays 2.
- occ = 3; flush together with resolve and push -> exactly one event emitted; next cycle occ = 0, rsv_rdy = 0. Resolve while empty -> err_udf = 1, no event.
- With BJP_TRK_STAT_EN: 6 resolves, 2 mismatched -> stat_total = 6, stat_miss = 2. Force stat_total to FFFF_FFFF, one more event -> value holds. Without the macro: both read 0.
